// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle FETCH_REQ..WRITEBACK state register with
// memory ready/wait handshakes, bounded-wait timeout fault, global stall
// and a retired-instruction counter.
module stage_sequencer #(
  parameter int WAIT_W       = 4,
  parameter int MAX_WAIT     = 15,
  parameter int CNT_W        = 32,
  parameter int SKIP_MEMREAD = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              stall,
  input  logic              mem_ready,
  input  logic              is_mem_op,
  input  logic              fault_clear,
  output logic [6:0]        state_onehot,
  output logic              mem_req,
  output logic              cir_we,
  output logic              decode_we,
  output logic              setup_we,
  output logic              mem_enable,
  output logic              result_we,
  output logic              pc_we,
  output logic              fault,
  output logic [WAIT_W-1:0] wait_count,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [2:0] {
    FETCH_REQ, FETCH_RECV, DECODE, SETUP, EXECUTE, MEMREAD, WRITEBACK, FAULT
  } state_t;

  state_t            state, stateNext;
  logic [WAIT_W-1:0] waitCount, waitNext;
  logic [CNT_W-1:0]  retireCount;
  logic              timeout;
  logic              strobeEn;

  // Timeout fires when the counter has already reached the limit and memory
  // is still not ready this cycle; ready on that same cycle still completes.
  assign timeout  = (waitCount == WAIT_W'(MAX_WAIT)) && !mem_ready;
  // Strobes die with stall and also while reset is held, so nothing is
  // requested from memory before the core is released.
  assign strobeEn = reset_n && !stall;

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH_REQ;
      waitCount   <= '0;
      retireCount <= '0;
    end else begin
      state     <= stateNext;
      waitCount <= waitNext;
      if (state == WRITEBACK && !stall)
        retireCount <= retireCount + CNT_W'(1);
    end
  end

  // Next-state and wait-count logic; everything freezes while stalled.
  always_comb begin
    stateNext = state;
    waitNext  = waitCount;
    if (!stall) begin
      case (state)
        FETCH_REQ:  if (run) stateNext = FETCH_RECV;
        FETCH_RECV: begin
          if (mem_ready) begin
            stateNext = DECODE;
            waitNext  = '0;
          end else if (timeout) begin
            stateNext = FAULT;
            waitNext  = '0;
          end else begin
            waitNext  = waitCount + WAIT_W'(1);
          end
        end
        DECODE:     stateNext = SETUP;
        SETUP:      stateNext = EXECUTE;
        EXECUTE:    stateNext = (is_mem_op || SKIP_MEMREAD == 0) ? MEMREAD : WRITEBACK;
        MEMREAD: begin
          if (!is_mem_op) begin
            // Non-memory op parked here for one cycle (SKIP_MEMREAD = 0).
            stateNext = WRITEBACK;
            waitNext  = '0;
          end else if (mem_ready) begin
            stateNext = WRITEBACK;
            waitNext  = '0;
          end else if (timeout) begin
            stateNext = FAULT;
            waitNext  = '0;
          end else begin
            waitNext  = waitCount + WAIT_W'(1);
          end
        end
        WRITEBACK:  stateNext = FETCH_REQ;
        FAULT:      if (fault_clear) stateNext = FETCH_REQ;
        default:    stateNext = FETCH_REQ;
      endcase
    end
  end

  // One-hot state view; FAULT shows as all-zero.
  always_comb begin
    state_onehot = '0;
    case (state)
      FETCH_REQ:  state_onehot = 7'b0000001;
      FETCH_RECV: state_onehot = 7'b0000010;
      DECODE:     state_onehot = 7'b0000100;
      SETUP:      state_onehot = 7'b0001000;
      EXECUTE:    state_onehot = 7'b0010000;
      MEMREAD:    state_onehot = 7'b0100000;
      WRITEBACK:  state_onehot = 7'b1000000;
      default:    state_onehot = '0;
    endcase
  end

  // Per-stage strobes decoded from state, gated by stall and reset.
  always_comb begin
    mem_req    = strobeEn && state == FETCH_REQ && run;
    cir_we     = strobeEn && state == FETCH_RECV && mem_ready;
    decode_we  = strobeEn && state == DECODE;
    setup_we   = strobeEn && state == SETUP;
    mem_enable = strobeEn && state == EXECUTE && is_mem_op;
    result_we  = strobeEn && (state == EXECUTE || state == WRITEBACK);
    pc_we      = strobeEn && state == WRITEBACK;
  end

  assign fault        = (state == FAULT);
  assign wait_count   = waitCount;
  assign retire_count = retireCount;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-cycle vector table through a scoreboard
// queue, plus hand sequences for async reset mid-MEMREAD and counter wrap.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, run, stall, mem_ready, is_mem_op, fault_clear;
  logic [6:0] state_onehot;
  logic       mem_req, cir_we, decode_we, setup_we, mem_enable, result_we, pc_we;
  logic       fault;
  logic [3:0] wait_count;
  logic [3:0] retire_count;
  logic [6:0] stbs;

  stage_sequencer #(.WAIT_W(4), .MAX_WAIT(15), .CNT_W(4), .SKIP_MEMREAD(1)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .stall(stall),
    .mem_ready(mem_ready), .is_mem_op(is_mem_op), .fault_clear(fault_clear),
    .state_onehot(state_onehot), .mem_req(mem_req), .cir_we(cir_we),
    .decode_we(decode_we), .setup_we(setup_we), .mem_enable(mem_enable),
    .result_we(result_we), .pc_we(pc_we), .fault(fault),
    .wait_count(wait_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // strobe vector order: mem_req, cir_we, decode_we, setup_we, mem_enable, result_we, pc_we
  assign stbs = {mem_req, cir_we, decode_we, setup_we, mem_enable, result_we, pc_we};

  typedef struct {
    logic [4:0] in;   // {run, stall, mem_ready, is_mem_op, fault_clear}
    logic [6:0] st;
    logic [6:0] stb;
    logic       flt;
    logic [3:0] wc;
    logic [3:0] rc;
  } vec_t;

  vec_t       vecs[$];
  vec_t       sb[$];
  int         nCmp = 0;
  int         nBad = 0;
  logic [3:0] rcRun = 4'd0;

  task automatic addRow(input logic [4:0] in, input logic [6:0] st, input logic [6:0] stb,
                        input logic flt, input logic [3:0] wc);
    vec_t v;
    v.in = in; v.st = st; v.stb = stb; v.flt = flt; v.wc = wc; v.rc = rcRun;
    vecs.push_back(v);
    if (st == 7'h40 && !in[3]) rcRun = rcRun + 4'd1;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t v, e;

    // A: non-memory op, zero-wait memory: 6 cycles
    addRow(5'b10100, 7'h01, 7'b1000000, 1'b0, 4'd0);
    addRow(5'b10100, 7'h02, 7'b0100000, 1'b0, 4'd0);
    addRow(5'b10100, 7'h04, 7'b0010000, 1'b0, 4'd0);
    addRow(5'b10100, 7'h08, 7'b0001000, 1'b0, 4'd0);
    addRow(5'b10100, 7'h10, 7'b0000010, 1'b0, 4'd0);
    addRow(5'b10100, 7'h40, 7'b0000011, 1'b0, 4'd0);
    // B: load with 3 wait cycles in MEMREAD
    addRow(5'b10110, 7'h01, 7'b1000000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h02, 7'b0100000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h04, 7'b0010000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h08, 7'b0001000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h10, 7'b0000110, 1'b0, 4'd0);
    addRow(5'b10010, 7'h20, 7'b0000000, 1'b0, 4'd0);
    addRow(5'b10010, 7'h20, 7'b0000000, 1'b0, 4'd1);
    addRow(5'b10010, 7'h20, 7'b0000000, 1'b0, 4'd2);
    addRow(5'b10110, 7'h20, 7'b0000000, 1'b0, 4'd3);
    addRow(5'b10110, 7'h40, 7'b0000011, 1'b0, 4'd0);
    // run low holds FETCH_REQ with no request
    addRow(5'b00100, 7'h01, 7'b0000000, 1'b0, 4'd0);
    addRow(5'b00100, 7'h01, 7'b0000000, 1'b0, 4'd0);
    // C: stall 4 cycles in EXECUTE, then stall with mem_ready in MEMREAD
    addRow(5'b10110, 7'h01, 7'b1000000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h02, 7'b0100000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h04, 7'b0010000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h08, 7'b0001000, 1'b0, 4'd0);
    for (int k = 0; k < 4; k++) addRow(5'b11110, 7'h10, 7'b0000000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h10, 7'b0000110, 1'b0, 4'd0);
    addRow(5'b11110, 7'h20, 7'b0000000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h20, 7'b0000000, 1'b0, 4'd0);
    addRow(5'b10110, 7'h40, 7'b0000011, 1'b0, 4'd0);
    // D: fetch timeout after 16 wait cycles, then fault handling
    addRow(5'b10100, 7'h01, 7'b1000000, 1'b0, 4'd0);
    addRow(5'b11000, 7'h02, 7'b0000000, 1'b0, 4'd0);
    for (int k = 0; k < 16; k++) addRow(5'b10000, 7'h02, 7'b0000000, 1'b0, 4'(k));
    addRow(5'b10100, 7'h00, 7'b0000000, 1'b1, 4'd0);
    addRow(5'b11101, 7'h00, 7'b0000000, 1'b1, 4'd0);
    addRow(5'b10101, 7'h00, 7'b0000000, 1'b1, 4'd0);
    addRow(5'b00101, 7'h01, 7'b0000000, 1'b0, 4'd0);
    // E: ready arrives exactly at the limit -> normal completion
    addRow(5'b10100, 7'h01, 7'b1000000, 1'b0, 4'd0);
    for (int k = 0; k < 15; k++) addRow(5'b10000, 7'h02, 7'b0000000, 1'b0, 4'(k));
    addRow(5'b10100, 7'h02, 7'b0100000, 1'b0, 4'd15);
    addRow(5'b10100, 7'h04, 7'b0010000, 1'b0, 4'd0);
    addRow(5'b10100, 7'h08, 7'b0001000, 1'b0, 4'd0);
    addRow(5'b10100, 7'h10, 7'b0000010, 1'b0, 4'd0);
    addRow(5'b10100, 7'h40, 7'b0000011, 1'b0, 4'd0);
    addRow(5'b00100, 7'h01, 7'b0000000, 1'b0, 4'd0);

    // Reset state, with run high to prove mem_req is held low
    reset_n = 1'b0; run = 1'b1; stall = 1'b0; mem_ready = 1'b1;
    is_mem_op = 1'b0; fault_clear = 1'b0;
    #3;
    chk("rst_state", -1, 32'(state_onehot), 32'h01);
    chk("rst_strobes", -1, 32'(stbs), 32'h00);
    chk("rst_fault", -1, 32'(fault), 32'h0);
    chk("rst_wait", -1, 32'(wait_count), 32'h0);
    chk("rst_retire", -1, 32'(retire_count), 32'h0);
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Table: drive after negedge, expected pushed, popped and compared 1ns later
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      v = vecs[i];
      {run, stall, mem_ready, is_mem_op, fault_clear} = v.in;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
      chk("state", i, 32'(state_onehot), 32'(e.st));
      chk("strobes", i, 32'(stbs), 32'(e.stb));
      chk("fault", i, 32'(fault), 32'(e.flt));
      chk("wait", i, 32'(wait_count), 32'(e.wc));
      chk("retire", i, 32'(retire_count), 32'(e.rc));
    end

    // Async reset in the middle of a MEMREAD wait
    @(negedge clk);
    run = 1'b1; stall = 1'b0; mem_ready = 1'b1; is_mem_op = 1'b1; fault_clear = 1'b0;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mr_state", -2, 32'(state_onehot), 32'h20);
    chk("mr_wait", -2, 32'(wait_count), 32'h1);
    chk("mr_retire", -2, 32'(retire_count), 32'(rcRun));
    #1 reset_n = 1'b0;
    #1;
    chk("arst_state", -2, 32'(state_onehot), 32'h01);
    chk("arst_strobes", -2, 32'(stbs), 32'h00);
    chk("arst_wait", -2, 32'(wait_count), 32'h0);
    chk("arst_retire", -2, 32'(retire_count), 32'h0);
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // 16 back-to-back non-memory ops: 4-bit retire counter wraps 15 -> 0
    @(negedge clk);
    run = 1'b1; mem_ready = 1'b1; is_mem_op = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      repeat (6) @(negedge clk);
      #1;
      chk("wrap_retire", i, 32'(retire_count), 32'(i % 16));
      chk("wrap_state", i, 32'(state_onehot), 32'h01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
